// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle radix-2 restoring divider for DIV/DIVU. It takes WIDTH
//   iterations per operation and returns {remainder, quotient} for the
//   HI/LO register (HI = remainder, LO = quotient).
//
//   Optional feature macro: DIV_SIGNED_EN
//     defined   : is_signed_i = 1 selects signed division (DIV). The quotient
//                 truncates toward zero and the remainder takes the sign of
//                 the dividend.
//     undefined : every operation is unsigned and is_signed_i is ignored.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   synchronous, active-high reset
//   start_i        in   request. Sampled only in IDLE or DONE.
//   dividend_i     in   numerator, captured when start is accepted
//   divisor_i      in   denominator, captured when start is accepted
//   is_signed_i    in   1 = DIV, 0 = DIVU (used only with DIV_SIGNED_EN)
//   busy_o         out  high while iterating
//   done_o         out  one-cycle pulse. The result is valid.
//   div_by_zero_o  out  divisor was zero. Valid with done and held.
//   div_ans_o      out  {remainder, quotient}. Registered and held.
// ----------------------------------------------------------------------------
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    input  logic               is_signed_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               div_by_zero_o,
    output logic [2*WIDTH-1:0] div_ans_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]    cnt_q;
    logic [WIDTH-1:0]   rem_q;      // partial remainder
    logic [WIDTH-1:0]   quo_q;      // dividend bits shift out at the MSB, quotient bits shift in at the LSB
    logic [WIDTH-1:0]   dvs_q;      // divisor magnitude
    logic [WIDTH-1:0]   dvd_raw_q;  // raw dividend, returned when dividing by zero
    logic               dbz_q;
    logic [2*WIDTH-1:0] ans_q;
    logic               dbz_out_q;

    logic               accept;
    logic               last_iter;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic [WIDTH-1:0]   dvd_mag;
    logic [WIDTH-1:0]   dvs_mag;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic [2*WIDTH-1:0] ans_fix;

    assign accept    = start_i && ((state_q == StIdle) || (state_q == StDone));
    assign last_iter = (state_q == StRun) && (cnt_q == LastCnt);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StRun;
            StRun:   if (cnt_q == LastCnt) state_d = StDone;
            StDone:  state_d = start_i ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy_o        = (state_q == StRun);
    assign done_o        = (state_q == StDone);
    assign div_by_zero_o = dbz_out_q;
    assign div_ans_o     = ans_q;

    // ------------------------------------------------------------------
    // Restoring iteration: the subtract is WIDTH+1 bits wide, so bit WIDTH
    // of the difference is the borrow. A clear borrow means rem' >= d.
    // ------------------------------------------------------------------
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        ge        = ~diff[WIDTH];
        rem_nxt   = ge ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_nxt   = {quo_q[WIDTH-2:0], ge};
    end

`ifdef DIV_SIGNED_EN
    logic neg_q_q;
    logic neg_r_q;
    logic dvd_neg;
    logic dvs_neg;

    always_comb begin
        dvd_neg = is_signed_i & dividend_i[WIDTH-1];
        dvs_neg = is_signed_i & divisor_i[WIDTH-1];
        // -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude.
        dvd_mag = dvd_neg ? (~dividend_i + 1'b1) : dividend_i;
        dvs_mag = dvs_neg ? (~divisor_i + 1'b1) : divisor_i;
        q_fix   = neg_q_q ? (~quo_nxt + 1'b1) : quo_nxt;
        r_fix   = neg_r_q ? (~rem_nxt + 1'b1) : rem_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (accept) begin
            neg_q_q <= dvd_neg ^ dvs_neg;
            neg_r_q <= dvd_neg;
        end
    end
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed_i;

    always_comb begin
        dvd_mag = dividend_i;
        dvs_mag = divisor_i;
        q_fix   = quo_nxt;
        r_fix   = rem_nxt;
    end
`endif

    assign ans_fix = dbz_q ? {dvd_raw_q, {WIDTH{1'b1}}} : {r_fix, q_fix};

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            dvd_raw_q <= '0;
            dbz_q     <= 1'b0;
            ans_q     <= '0;
            dbz_out_q <= 1'b0;
        end else if (accept) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= dvd_mag;
            dvs_q     <= dvs_mag;
            dvd_raw_q <= dividend_i;
            dbz_q     <= (divisor_i == '0);
        end else if (state_q == StRun) begin
            cnt_q <= cnt_q + 1'b1;
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            // Only the final iteration updates the visible result.
            if (last_iter) begin
                ans_q     <= ans_fix;
                dbz_out_q <= dbz_q;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        is_signed;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [63:0] ans;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .is_signed_i   (is_signed),
        .busy_o        (busy),
        .done_o        (done),
        .div_by_zero_o (dbz),
        .div_ans_o     (ans)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division. Bit 64 is the div-by-zero flag.
    function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
`ifdef DIV_SIGNED_EN
        if (s) begin
            longint sa;
            longint sb;
            longint sq;
            longint sr;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[31:0];
            r  = sr[31:0];
            return {1'b0, r, q};
        end
`endif
        q = a / b;
        r = a % b;
        return {1'b0, r, q};
    endfunction

    // Drive a request in the cycle before the next edge. The edge is the accept edge.
    task automatic accept_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        @(posedge clk);
        #1;
    endtask

    // Counts edges with the accept edge as edge 1. done is expected to be seen
    // high after edge 33. The operands are scrambled after accept. When
    // inj > 0, a 9/3 start is pulsed before edge inj and must be ignored.
    task automatic wait_done(input int inj, output int n, output logic got);
        n   = 1;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start     = (n + 1 == inj);
            dividend  = (n + 1 == inj) ? 32'd9 : $urandom;
            divisor   = (n + 1 == inj) ? 32'd3 : $urandom;
            is_signed = 1'($urandom);
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic s, input int n, input logic got);
        logic [64:0] m;
        m = model(a, b, s);
        check({tag, " done"}, 64'(got), 64'd1);
        check({tag, " latency"}, 64'(n), 64'd33);
        check({tag, " ans"}, ans, m[63:0]);
        check({tag, " dbz"}, 64'(dbz), 64'(m[64]));
        check({tag, " busy@done"}, 64'(busy), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s);
        int   n;
        logic got;
        logic [63:0] held;
        accept_op(a, b, s);
        check({tag, " busy@accept"}, 64'(busy), 64'd1);
        wait_done(0, n, got);
        check_result(tag, a, b, s, n, got);
        held = ans;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " done pulse"}, 64'(done), 64'd0);
        check({tag, " ans held"}, ans, held);
    endtask

    initial begin
        int          n;
        int          pulses;
        logic        got;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;

        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0; is_signed = 1'b0;

        // 1. reset, then idle
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset ans", ans, 64'd0);
        check("reset dbz", 64'(dbz), 64'd0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        check("idle activity", 64'(pulses), 64'd0);
        check("idle ans", ans, 64'd0);

        // 2./3. directed DIVU
        run_op("divu 100/7", 32'd100, 32'd7, 1'b0);
        check("divu 100/7 const", ans, 64'h00000002_0000000E);
        run_op("divu 5/0", 32'd5, 32'd0, 1'b0);
        check("divu 5/0 const", ans, 64'h00000005_FFFFFFFF);

        // 4. start during RUN is ignored, start in DONE is accepted
        accept_op(32'd100, 32'd7, 1'b0);
        wait_done(10, n, got);
        check_result("ignore", 32'd100, 32'd7, 1'b0, n, got);
        check("ignore const", ans, 64'h00000002_0000000E);
        accept_op(32'd9, 32'd3, 1'b0);
        check("b2b busy", 64'(busy), 64'd1);
        wait_done(0, n, got);
        check_result("b2b", 32'd9, 32'd3, 1'b0, n, got);
        check("b2b const", ans, 64'h00000000_00000003);

        // 5. reset mid-run aborts
        accept_op(32'hFFFF_FFFF, 32'd1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort ans", ans, 64'd0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("abort no done", 64'(pulses), 64'd0);
        run_op("divu 8/2", 32'd8, 32'd2, 1'b0);
        check("divu 8/2 const", ans, 64'h00000000_00000004);

`ifdef DIV_SIGNED_EN
        // 6. signed cases
        run_op("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        check("div -7/2 const", ans, 64'hFFFFFFFF_FFFFFFFD);
        run_op("div 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        check("div 7/-2 const", ans, 64'h00000001_FFFFFFFD);
        run_op("div min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check("div min/-1 const", ans, 64'h00000000_80000000);
        run_op("div -5/0", 32'hFFFF_FFFB, 32'd0, 1'b1);
`endif
        run_op("divu -7/2", 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("divu -7/2 const", ans, 64'h00000001_7FFFFFFC);

        // randomized operations against the model
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 9));
                1:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) a = {{16{a[15]}}, a[15:0]};
            s = 1'($urandom);
            run_op("random", a, b, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
